// File: rtl/matrix_key_scan.sv
// matrix_key_scan: 4x4 active-low key matrix scanner.
// Drives one column low per slot, samples the synchronized rows at the end of
// each slot, and debounces whole-matrix snapshots once per full scan. It emits
// a one-cycle key_flag with key_code (row*4 + col) when the accepted snapshot
// goes from empty to exactly one key.
// Optional feature: define MATRIX_KEY_REPEAT_EN for periodic auto-repeat
// flags while the same single key stays accepted.
module matrix_key_scan #(
    parameter logic [15:0] SCAN_DIV       = 16'd1000,
    parameter logic [7:0]  DEBOUNCE_SCANS = 8'd4,
    parameter logic [7:0]  REPEAT_SCANS   = 8'd50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_flag,
    output logic       key_held
);

    // Snapshot layout is column-major: bit col*4 + row.
    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    logic [15:0] slot_cnt;
    logic [1:0]  col;
    logic        slot_last;
    logic        scan_end;
    logic [15:0] snap;
    logic [15:0] snap_full;
    logic [15:0] prev_snap;
    logic [15:0] accepted;
    logic [15:0] acc_next;
    logic [7:0]  stable_cnt;
    logic [7:0]  stable_next;
    logic        accept_upd;
    logic        acc_onehot;
    logic        first_press;
    logic        flag_next;
    logic [3:0]  code_next;

    // Two-flop synchronizer for the asynchronous row inputs (idle = pulled up).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Slot timer and column index; column advances at the end of every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            col      <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            col      <= col + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + 16'd1;
        end
    end

    // Active-low one-cold column drive.
    always_comb begin
        col_out = ~(4'b0001 << col);
    end

    // Scan-end evaluation: merge the column-3 sample, update debounce count,
    // and decide whether the accepted snapshot changes this cycle.
    always_comb begin
        slot_last          = (slot_cnt == SCAN_DIV - 16'd1);
        scan_end           = slot_last && (col == 2'd3);
        snap_full          = snap;
        snap_full[15:12]   = ~row_sync;
        if (snap_full == prev_snap) begin
            stable_next = (stable_cnt >= DEBOUNCE_SCANS) ? DEBOUNCE_SCANS
                                                         : stable_cnt + 8'd1;
        end else begin
            stable_next = '0;
        end
        accept_upd  = scan_end && (stable_next == DEBOUNCE_SCANS);
        acc_next    = accept_upd ? snap_full : accepted;
        acc_onehot  = (acc_next != '0) && ((acc_next & (acc_next - 16'd1)) == '0);
        first_press = accept_upd && (accepted == '0) && acc_onehot;
    end

    // Translate the column-major bit index to row*4 + col.
    always_comb begin
        code_next = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (acc_next[i]) begin
                code_next = {i[1:0], i[3:2]};
            end
        end
    end

    // Snapshot capture at each slot end; debounce state updates at scan end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap       <= '0;
            prev_snap  <= '0;
            stable_cnt <= '0;
            accepted   <= '0;
        end else begin
            if (slot_last) begin
                snap[{col, 2'b00} +: 4] <= ~row_sync;
            end
            if (scan_end) begin
                prev_snap  <= snap_full;
                stable_cnt <= stable_next;
                if (accept_upd) begin
                    accepted <= snap_full;
                end
            end
        end
    end

`ifdef MATRIX_KEY_REPEAT_EN
    logic [7:0] rep_cnt;
    logic       rep_active;
    logic       rep_fire;

    // A repeat fires only while the accepted key is unchanged this scan.
    always_comb begin
        rep_fire  = scan_end && rep_active && (acc_next == accepted) &&
                    (rep_cnt == REPEAT_SCANS - 8'd1);
        flag_next = first_press || rep_fire;
    end

    // Scan counter armed by the initial flag; any change of accepted clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt    <= '0;
            rep_active <= 1'b0;
        end else if (scan_end) begin
            if (first_press) begin
                rep_cnt    <= '0;
                rep_active <= 1'b1;
            end else if (acc_next != accepted) begin
                rep_cnt    <= '0;
                rep_active <= 1'b0;
            end else if (rep_active) begin
                rep_cnt <= rep_fire ? 8'd0 : rep_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_repeat;

    // Without auto-repeat only the initial press produces a flag.
    always_comb begin
        flag_next     = first_press;
        unused_repeat = ^REPEAT_SCANS;
    end
`endif

    // Registered outputs: flag, code and held all change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_flag <= 1'b0;
            key_code <= '0;
            key_held <= 1'b0;
        end else begin
            key_flag <= flag_next;
            key_held <= (acc_next != '0);
            if (first_press) begin
                key_code <= code_next;
            end
        end
    end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Scoreboard bench for matrix_key_scan with SCAN_DIV=4 (16-cycle scans),
// DEBOUNCE_SCANS=3, REPEAT_SCANS=5. Key state changes are aligned to scan
// starts, so a key stable from scan k is flagged on cycle 16*(k+4).
module tb_matrix_key_scan;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_flag;
    logic        key_held;
    logic [15:0] keys = '0;   // indexed by key code row*4 + col
    int          cyc;
    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb[$];

    matrix_key_scan #(
        .SCAN_DIV      (16'd4),
        .DEBOUNCE_SCANS(8'd3),
        .REPEAT_SCANS  (8'd5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_in  (row_in),
        .col_out (col_out),
        .key_code(key_code),
        .key_flag(key_flag),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    // Cycle index since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_flag(input int code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Monitor: every flag must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && key_flag) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_flag: key_code=%0d at cycle %0d, none expected", key_code, cyc);
            end else begin
                e = sb.pop_front();
                check("flag_cycle", cyc, e.cyc);
                check("flag_code", {28'd0, key_code}, e.code);
                check("flag_held", {31'd0, key_held}, 1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] exp_col;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_col", {28'd0, col_out}, 4'b1110);
        check("rst_code", {28'd0, key_code}, 0);
        check("rst_flag", {31'd0, key_flag}, 0);
        check("rst_held", {31'd0, key_held}, 0);
        rst_n = 1'b1;

        // Idle column sequence over two scans
        for (int n = 0; n < 32; n++) begin
            at_cycle(n);
            exp_col = 4'b1111;
            exp_col[(n / 4) % 4] = 1'b0;
            check("col_seq", {28'd0, col_out}, exp_col);
        end

        // Clean press of key 9 (row 2, col 1) from scan 2, held 10 scans
        keys[9] = 1'b1;
        expect_flag(9, 96);
        at_cycle(100);
        check("held_k9", {31'd0, key_held}, 1);
        check("code_k9", {28'd0, key_code}, 9);
        at_cycle(192);
        keys = '0;
        at_cycle(255);
        check("held_before_release", {31'd0, key_held}, 1);
        at_cycle(256);
        check("held_after_release", {31'd0, key_held}, 0);

        // Bounce on key 5 for two scans (pressed in scan 16, open in scan 17)
        for (int n = 256; n < 288; n++) begin
            at_cycle(n);
            keys[5] = (((n - 256 + 1) / 3) % 2 == 0);
        end
        at_cycle(288);
        keys[5] = 1'b1;
        expect_flag(5, 352);
        at_cycle(352);
        keys = '0;
        at_cycle(415);
        check("held_k5", {31'd0, key_held}, 1);
        at_cycle(416);
        check("held_k5_release", {31'd0, key_held}, 0);

        // Keys 0 and 15 together: no flag, held; roll-over to key 0: no flag
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        at_cycle(480);
        check("held_multi", {31'd0, key_held}, 1);
        check("code_multi", {28'd0, key_code}, 5);
        keys[15] = 1'b0;
        at_cycle(544);
        check("held_rollover", {31'd0, key_held}, 1);
        check("code_rollover", {28'd0, key_code}, 5);
        keys = '0;
        at_cycle(608);
        check("held_all_released", {31'd0, key_held}, 0);
        keys[15] = 1'b1;
        expect_flag(15, 672);
        at_cycle(672);
        keys = '0;
        at_cycle(736);
        check("held_k15_release", {31'd0, key_held}, 0);

        // Reset in the middle of debouncing key 3, key kept held
        keys[3] = 1'b1;
        at_cycle(776);
        rst_n = 1'b0;
        #1;
        check("midrst_col", {28'd0, col_out}, 4'b1110);
        check("midrst_code", {28'd0, key_code}, 0);
        check("midrst_flag", {31'd0, key_flag}, 0);
        check("midrst_held", {31'd0, key_held}, 0);
        check("midrst_sb_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_flag(3, 64);
        at_cycle(65);
        check("code_k3", {28'd0, key_code}, 3);
        keys = '0;
        at_cycle(128);
        check("held_k3_release", {31'd0, key_held}, 0);

        // Key 7 held 16 scans after its initial flag
        keys[7] = 1'b1;
        expect_flag(7, 192);
`ifdef MATRIX_KEY_REPEAT_EN
        expect_flag(7, 272);
        expect_flag(7, 352);
        expect_flag(7, 432);
`endif
        at_cycle(448);
        keys = '0;
        at_cycle(511);
        check("held_k7", {31'd0, key_held}, 1);
        at_cycle(512);
        check("held_k7_release", {31'd0, key_held}, 0);
        at_cycle(560);
        check("all_flags_seen", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
